aclk_keypad_scan: RTL and testbench
===================================

// Module: aclk_keypad_scan
// PURPOSE
//  Scans a 4x4 active-low matrix keypad, debounces a press and emits the 4-bit key code
//  with a one-cycle shift strobe. Producer side of the key/shift interface that loads the
//  alarm-clock key buffer. Sits between the keypad pins and the key shift register / FSM.
// PARAMETERS
//  SCAN_DIV      4096  clocks each column is driven before the next column is selected (>=4)
//  DEBOUNCE_CNT  20000 consecutive stable clocks required to accept a press or a release (>=2)
//  REPEAT_CYCLES 1e6   held-key repeat interval in clocks (used only with ACLK_KEY_REPEAT_EN)
// PORTS
//  clock     in   1  system clock
//  reset     in   1  asynchronous, active-high
//  row_in    in   4  keypad rows, active-low, asynchronous to clock
//  col_out   out  4  keypad column drive, active-low, exactly one bit low at any time
//  key       out  4  code of last accepted key, stable while shift=1 and held until next press
//  shift     out  1  one-cycle strobe: key is valid, load it into the key buffer
//  digit     out  1  1 when key is 0-9 (qualifies shift for digit entry)
//  key_held  out  1  1 from the press strobe until the release is debounced
// BEHAVIOUR
//  - Reset: col_out=4'b1110 (col 0), key=4'h0, shift=0, digit=0, key_held=0, state SCAN, counters 0.
//  - row_in passes a 2-flop synchroniser -> row_s; all decisions use row_s.
//  - Key map [row][col]: r0: 1 2 3 A | r1: 4 5 6 B | r2: 7 8 9 C | r3: *(E) 0 #(F) D;
//    A..D = 10..13, *=14, #=15; digit = (code < 10).
//  - SCAN: dwell counter counts 0..SCAN_DIV-1 per column; row_s sampled only on last dwell cycle.
//    row_s==4'hF -> rotate col_out left (1110->1101->1011->0111->1110), dwell restarts.
//    Else latch col and lowest-index low row bit (multi-row press: lowest row wins) -> DEBOUNCE,
//    column frozen.
//  - DEBOUNCE: counts DEBOUNCE_CNT cycles; any cycle with row_s != latched pattern -> SCAN and
//    advance column (press rejected, no strobe). Count complete -> PRESS.
//  - PRESS: exactly one cycle; key/digit updated and shift=1 in this cycle; key_held=1 -> HOLD.
//  - HOLD: column frozen; shift=0. row_s==4'hF for DEBOUNCE_CNT consecutive cycles -> SCAN,
//    key_held=0, column advances; any non-released cycle clears the release counter.
//  - Latency: shift rises DEBOUNCE_CNT+1 clocks after the accepting sample cycle.
//  - Second key pressed while holding first: ignored; no strobe until full release then rescan.
//  - key/digit never change except in PRESS (or a repeat strobe); shift never high 2 cycles in a row.
//  - Reset mid-operation: immediate return to reset values, any pending strobe is lost.
// CONFIGURATION
//  ACLK_KEY_REPEAT_EN defined: in HOLD a repeat counter runs; every REPEAT_CYCLES clocks of
//   continuous hold, shift pulses one cycle with the same key; counter clears on entering HOLD
//   and on any strobe. Release debounce unchanged.
//  Not defined: exactly one shift per press; REPEAT_CYCLES ignored, no repeat logic synthesised.
// STRUCTURE
//  - aclk_pkg: key code localparams (KEY_A..KEY_D, KEY_STAR=14, KEY_HASH=15), state encoding
//    typedef {SCAN, DEBOUNCE, PRESS, HOLD}, function key_code(row_idx, col_idx).
//  - Sub-module aclk_sync2: parameterised-width 2-flop synchroniser with async reset (4'hF).
//  - Top holds FSM, dwell/debounce/repeat counters, column rotator, output registers.
// TESTING  (SCAN_DIV=4, DEBOUNCE_CNT=8, REPEAT_CYCLES=32)
//  1 Reset: col_out=1110, key=0, shift=0, key_held=0; idle rows -> col_out rotates every 4 clocks.
//  2 Press '5' (row1 low while col1 driven) stable -> one shift, key=5, digit=1, col_out held 1101
//    until release debounced; then scan resumes at col2.
//  3 Bounce: row low 3 cycles then high during DEBOUNCE -> no shift, scan continues.
//  4 Press '#' (row3, col2) -> key=15, digit=0; then press '0' -> key=0, digit=1, two strobes total.
//  5 Rows 1 and 2 low together on col0 -> key=4 (lowest row wins); second key during hold ignored.
//  6 With ACLK_KEY_REPEAT_EN, hold '9' 100 clocks past PRESS -> 3 additional shift pulses 32 apart,
//    key=9; without macro -> exactly one pulse. Reset asserted in HOLD -> reset values next edge.

Source files
------------

// File: rtl/aclk_pkg.sv
// Shared definitions for the alarm-clock keypad scanner: key codes, scan states and the
// row/column to key-code mapping.
package aclk_pkg;

  localparam logic [3:0] KEY_A    = 4'd10;
  localparam logic [3:0] KEY_B    = 4'd11;
  localparam logic [3:0] KEY_C    = 4'd12;
  localparam logic [3:0] KEY_D    = 4'd13;
  localparam logic [3:0] KEY_STAR = 4'd14;
  localparam logic [3:0] KEY_HASH = 4'd15;

  typedef enum logic [1:0] {
    SCAN     = 2'd0,
    DEBOUNCE = 2'd1,
    PRESS    = 2'd2,
    HOLD     = 2'd3
  } scan_state_e;

  // Keypad layout: r0 1 2 3 A | r1 4 5 6 B | r2 7 8 9 C | r3 * 0 # D
  function automatic logic [3:0] key_code(input logic [1:0] row_idx, input logic [1:0] col_idx);
    logic [3:0] code;
    case ({row_idx, col_idx})
      4'h0:    code = 4'd1;
      4'h1:    code = 4'd2;
      4'h2:    code = 4'd3;
      4'h3:    code = KEY_A;
      4'h4:    code = 4'd4;
      4'h5:    code = 4'd5;
      4'h6:    code = 4'd6;
      4'h7:    code = KEY_B;
      4'h8:    code = 4'd7;
      4'h9:    code = 4'd8;
      4'hA:    code = 4'd9;
      4'hB:    code = KEY_C;
      4'hC:    code = KEY_STAR;
      4'hD:    code = 4'd0;
      4'hE:    code = KEY_HASH;
      default: code = KEY_D;
    endcase
    return code;
  endfunction

  // Index of the lowest active-low row; with several rows down the lowest one wins.
  function automatic logic [1:0] low_row(input logic [3:0] rows);
    logic [1:0] idx;
    idx = 2'd0;
    for (int i = 3; i >= 0; i--) begin
      if (!rows[i]) idx = 2'(i);
    end
    return idx;
  endfunction

endpackage

// File: rtl/aclk_keypad_scan_if.sv
// Key/shift interface between the keypad scanner (master) and the key buffer (slave).
interface aclk_keypad_scan_if;
  logic [3:0] key;
  logic       shift;
  logic       digit;
  logic       key_held;

  modport master (output key, output shift, output digit, output key_held);
  modport slave  (input key, input shift, input digit, input key_held);
endinterface

// File: rtl/aclk_sync2.sv
// Two-flop synchroniser, per-bit chains, asynchronous reset to RST_VAL.
module aclk_sync2 #(
  parameter int               WIDTH   = 4,
  parameter logic [WIDTH-1:0] RST_VAL = '1
) (
  input  logic             clock,
  input  logic             reset,
  input  logic [WIDTH-1:0] d,
  output logic [WIDTH-1:0] q
);

  genvar gi;
  generate
    for (gi = 0; gi < WIDTH; gi++) begin : g_bit
      logic meta_q;
      logic sync_q;
      always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
          meta_q <= RST_VAL[gi];
          sync_q <= RST_VAL[gi];
        end else begin
          meta_q <= d[gi];
          sync_q <= meta_q;
        end
      end
      assign q[gi] = sync_q;
    end
  endgenerate

endmodule

// File: rtl/aclk_keypad_scan.sv
// 4x4 active-low keypad scanner with press/release debounce and a one-cycle key strobe.
// Optional held-key auto-repeat is built only when ACLK_KEY_REPEAT_EN is defined.
module aclk_keypad_scan
  import aclk_pkg::*;
#(
  parameter int SCAN_DIV      = 4096,
  parameter int DEBOUNCE_CNT  = 20000,
  parameter int REPEAT_CYCLES = 1000000
) (
  input  logic                clock,
  input  logic                reset,
  input  logic [3:0]          row_in,
  output logic [3:0]          col_out,
  aclk_keypad_scan_if.master  key_bus
);

  localparam int DW = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
  localparam int BW = (DEBOUNCE_CNT > 1) ? $clog2(DEBOUNCE_CNT) : 1;
  localparam logic [DW-1:0] DWELL_LAST = DW'(SCAN_DIV - 1);
  localparam logic [BW-1:0] STAB_LAST  = BW'(DEBOUNCE_CNT - 1);

  logic [3:0] row_s;

  aclk_sync2 #(.WIDTH(4), .RST_VAL(4'hF)) u_sync (
    .clock (clock),
    .reset (reset),
    .d     (row_in),
    .q     (row_s)
  );

  scan_state_e   state_q, state_d;
  logic [DW-1:0] dwell_q, dwell_d;
  // Shared between press debounce and release debounce; the two never overlap.
  logic [BW-1:0] stab_q, stab_d;
  logic [1:0]    col_q, col_d;
  logic [3:0]    col_out_q, col_out_d;
  logic [3:0]    pat_q, pat_d;
  logic [1:0]    row_q, row_d;
  logic [3:0]    key_q, key_d;
  logic          shift_q, shift_d;
  logic          digit_q, digit_d;
  logic          held_q, held_d;
  logic [3:0]    press_code;

`ifdef ACLK_KEY_REPEAT_EN
  localparam int RW = (REPEAT_CYCLES > 1) ? $clog2(REPEAT_CYCLES) : 1;
  localparam logic [RW-1:0] REP_LAST = RW'(REPEAT_CYCLES - 1);
  // Cycles since the last strobe, counted only while the key stays down.
  logic [RW-1:0] rep_q, rep_d;
`else
  if (REPEAT_CYCLES > 0) begin : g_no_repeat
  end
`endif

  assign press_code = key_code(row_q, col_q);

  always_comb begin
    state_d = state_q;
    dwell_d = dwell_q;
    stab_d  = stab_q;
    col_d   = col_q;
    pat_d   = pat_q;
    row_d   = row_q;
    key_d   = key_q;
    shift_d = 1'b0;
    digit_d = digit_q;
    held_d  = held_q;
`ifdef ACLK_KEY_REPEAT_EN
    rep_d   = rep_q;
`endif

    case (state_q)
      SCAN: begin
        if (dwell_q == DWELL_LAST) begin
          dwell_d = '0;
          if (row_s == 4'hF) begin
            col_d = col_q + 2'd1;
          end else begin
            pat_d   = row_s;
            row_d   = low_row(row_s);
            stab_d  = '0;
            state_d = DEBOUNCE;
          end
        end else begin
          dwell_d = dwell_q + 1'b1;
        end
      end

      DEBOUNCE: begin
        if (row_s != pat_q) begin
          state_d = SCAN;
          col_d   = col_q + 2'd1;
          dwell_d = '0;
        end else if (stab_q == STAB_LAST) begin
          state_d = PRESS;
          key_d   = press_code;
          digit_d = (press_code < KEY_A);
          shift_d = 1'b1;
          held_d  = 1'b1;
`ifdef ACLK_KEY_REPEAT_EN
          rep_d   = '0;
`endif
        end else begin
          stab_d = stab_q + 1'b1;
        end
      end

      PRESS: begin
        state_d = HOLD;
        stab_d  = '0;
`ifdef ACLK_KEY_REPEAT_EN
        rep_d   = rep_q + 1'b1;
`endif
      end

      default: begin // HOLD
        if (row_s == 4'hF) begin
`ifdef ACLK_KEY_REPEAT_EN
          rep_d = '0;
`endif
          if (stab_q == STAB_LAST) begin
            state_d = SCAN;
            held_d  = 1'b0;
            col_d   = col_q + 2'd1;
            dwell_d = '0;
          end else begin
            stab_d = stab_q + 1'b1;
          end
        end else begin
          stab_d = '0;
`ifdef ACLK_KEY_REPEAT_EN
          if (rep_q == REP_LAST) begin
            shift_d = 1'b1;
            rep_d   = '0;
          end else begin
            rep_d = rep_q + 1'b1;
          end
`endif
        end
      end
    endcase

    col_out_d = ~(4'b0001 << col_d);
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_q   <= SCAN;
      dwell_q   <= '0;
      stab_q    <= '0;
      col_q     <= 2'd0;
      col_out_q <= 4'b1110;
      pat_q     <= 4'hF;
      row_q     <= 2'd0;
      key_q     <= 4'h0;
      shift_q   <= 1'b0;
      digit_q   <= 1'b0;
      held_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      dwell_q   <= dwell_d;
      stab_q    <= stab_d;
      col_q     <= col_d;
      col_out_q <= col_out_d;
      pat_q     <= pat_d;
      row_q     <= row_d;
      key_q     <= key_d;
      shift_q   <= shift_d;
      digit_q   <= digit_d;
      held_q    <= held_d;
    end
  end

`ifdef ACLK_KEY_REPEAT_EN
  always_ff @(posedge clock or posedge reset) begin
    if (reset) rep_q <= '0;
    else       rep_q <= rep_d;
  end
`endif

  assign col_out          = col_out_q;
  assign key_bus.key      = key_q;
  assign key_bus.shift    = shift_q;
  assign key_bus.digit    = digit_q;
  assign key_bus.key_held = held_q;

endmodule

// File: tb/tb_aclk_keypad_scan.sv
// Bench for aclk_keypad_scan: a keypad model drives row_in from col_out, a procedural
// reference model predicts every output each cycle, plus directed checks of key scenarios.
`timescale 1ns/1ps
module tb_aclk_keypad_scan;

  localparam int SD = 4;
  localparam int DB = 8;
  localparam int RP = 32;

  logic       clock = 1'b0;
  logic       reset = 1'b1;
  logic [3:0] row_in;
  logic [3:0] col_out;

  aclk_keypad_scan_if kb();

  aclk_keypad_scan #(.SCAN_DIV(SD), .DEBOUNCE_CNT(DB), .REPEAT_CYCLES(RP)) dut (
    .clock   (clock),
    .reset   (reset),
    .row_in  (row_in),
    .col_out (col_out),
    .key_bus (kb)
  );

  always #5 clock = ~clock;

  // Keypad: keys[r*4+c] pressed pulls row r low while column c is driven low.
  logic [15:0] keys    = '0;
  logic        ovr_en  = 1'b0;
  logic [3:0]  ovr_val = 4'hF;
  logic [3:0]  pad_rows;
  always_comb begin
    pad_rows = 4'hF;
    for (int r = 0; r < 4; r++)
      for (int c = 0; c < 4; c++)
        if (keys[r*4+c] && !col_out[c]) pad_rows[r] = 1'b0;
  end
  assign row_in = ovr_en ? ovr_val : pad_rows;

  int keymap [16] = '{1, 2, 3, 10, 4, 5, 6, 11, 7, 8, 9, 12, 14, 0, 15, 13};

  int total = 0;
  int bad   = 0;

  task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  // Rows as the design sees them after its two-stage synchroniser.
  logic [3:0] s1, s2;
  always @(posedge clock or posedge reset) begin
    if (reset) begin
      s1 <= 4'hF;
      s2 <= 4'hF;
    end else begin
      s1 <= row_in;
      s2 <= s1;
    end
  end

  int         e_col   = 0;
  logic [3:0] e_key   = 4'h0;
  logic       e_shift = 1'b0;
  logic       e_digit = 1'b0;
  logic       e_held  = 1'b0;
  bit         ab      = 1'b0;

  // One clock edge of the reference; flags an abort when reset arrives instead.
  task automatic mtick(output logic [3:0] r);
    @(posedge clock or posedge reset);
    ab      = reset;
    r       = s2;
    e_shift = 1'b0;
  endtask

  initial begin : ref_model
    logic [3:0] r, pat;
    int         rr, rel;
    bit         ok;
`ifdef ACLK_KEY_REPEAT_EN
    int         rep;
`endif
    forever begin
      e_col = 0; e_key = 4'h0; e_shift = 1'b0; e_digit = 1'b0; e_held = 1'b0;
      if (reset) @(negedge reset);
      ab = 1'b0;
      while (!ab) begin
        r = 4'hF;
        for (int d = 0; d < SD && !ab; d++) mtick(r);
        if (ab) break;
        if (r == 4'hF) begin
          e_col = (e_col + 1) % 4;
          continue;
        end
        pat = r;
        rr  = 0;
        for (int i = 3; i >= 0; i--) if (!pat[i]) rr = i;
        ok = 1'b1;
        for (int i = 0; i < DB && !ab && ok; i++) begin
          mtick(r);
          if (!ab && r != pat) ok = 1'b0;
        end
        if (ab) break;
        if (!ok) begin
          e_col = (e_col + 1) % 4;
          continue;
        end
        e_key   = 4'(keymap[rr*4 + e_col]);
        e_digit = (e_key < 4'd10);
        e_shift = 1'b1;
        e_held  = 1'b1;
        mtick(r);
        if (ab) break;
        rel = 0;
`ifdef ACLK_KEY_REPEAT_EN
        rep = 1;
`endif
        while (!ab) begin
          mtick(r);
          if (ab) break;
          if (r == 4'hF) begin
            rel++;
`ifdef ACLK_KEY_REPEAT_EN
            rep = 0;
`endif
            if (rel == DB) break;
          end else begin
            rel = 0;
`ifdef ACLK_KEY_REPEAT_EN
            rep++;
            if (rep == RP) begin
              e_shift = 1'b1;
              rep     = 0;
            end
`endif
          end
        end
        if (ab) break;
        e_held = 1'b0;
        e_col  = (e_col + 1) % 4;
      end
    end
  end

  bit chk_on = 1'b0;
  always @(negedge clock) begin
    if (chk_on) begin
      check_val("col_out", 32'(col_out), 32'(4'hF ^ (4'b0001 << e_col)));
      check_val("shift", 32'(kb.shift), 32'(e_shift));
      check_val("key", 32'(kb.key), 32'(e_key));
      check_val("digit", 32'(kb.digit), 32'(e_digit));
      check_val("key_held", 32'(kb.key_held), 32'(e_held));
    end
  end

  int n_shift = 0;
  always @(posedge clock) if (!reset && kb.shift) n_shift <= n_shift + 1;

  task automatic cyc(input int n);
    repeat (n) @(negedge clock);
  endtask

  task automatic wait_shift(input string tag, input int limit);
    int n = 0;
    while (kb.shift !== 1'b1 && n < limit) begin
      @(negedge clock);
      n++;
    end
    check_val(tag, 32'(kb.shift), 32'd1);
  endtask

  task automatic pulse_reset(input int n);
    #2 reset = 1'b1;
    repeat (n) @(negedge clock);
    #2 reset = 1'b0;
    @(negedge clock);
  endtask

  initial begin : stimulus
    int n0, cnt, exp_rep;
    cyc(1);
    chk_on = 1'b1;
    cyc(2);
    check_val("rst_col", 32'(col_out), 32'h E);
    check_val("rst_key", 32'(kb.key), 32'h0);
    #2 reset = 1'b0;
    cyc(40);

    // '5' at row1/col1
    keys = 16'(1) << 5;
    wait_shift("seen_5", 200);
    check_val("key_5", 32'(kb.key), 32'd5);
    check_val("digit_5", 32'(kb.digit), 32'd1);
    cyc(20);
    check_val("hold_col_5", 32'(col_out), 32'b1101);
    check_val("held_5", 32'(kb.key_held), 32'd1);
    keys = '0;
    cyc(20);
    check_val("released_5", 32'(kb.key_held), 32'd0);

    // Bounce shorter than the debounce window
    n0 = n_shift;
    ovr_en = 1'b1; ovr_val = 4'b1101;
    cyc(6);
    ovr_en = 1'b0;
    cyc(30);
    check_val("bounce_strobes", 32'(n_shift - n0), 32'd0);

    // '#' then '0'
    n0 = n_shift;
    keys = 16'(1) << 14;
    wait_shift("seen_hash", 200);
    check_val("key_hash", 32'(kb.key), 32'd15);
    check_val("digit_hash", 32'(kb.digit), 32'd0);
    cyc(15); keys = '0; cyc(25);
    keys = 16'(1) << 13;
    wait_shift("seen_0", 200);
    check_val("key_0", 32'(kb.key), 32'd0);
    check_val("digit_0", 32'(kb.digit), 32'd1);
    cyc(15); keys = '0; cyc(25);
    check_val("two_strobes", 32'(n_shift - n0), 32'd2);

    // '4' and '7' together, then '2' during hold
    n0 = n_shift;
    keys = (16'(1) << 4) | (16'(1) << 8);
    wait_shift("seen_4", 200);
    check_val("key_4", 32'(kb.key), 32'd4);
    keys = keys | (16'(1) << 1);
    cyc(28);
    check_val("second_ignored_key", 32'(kb.key), 32'd4);
    check_val("second_ignored_cnt", 32'(n_shift - n0), 32'd1);
    keys = '0; cyc(30);

    // Hold '9' for 100 clocks past the press strobe, then reset in HOLD
    keys = 16'(1) << 10;
    wait_shift("seen_9", 200);
    cnt = 0;
    for (int i = 0; i < 100; i++) begin
      @(negedge clock);
      if (kb.shift) cnt++;
    end
`ifdef ACLK_KEY_REPEAT_EN
    exp_rep = 3;
`else
    exp_rep = 0;
`endif
    check_val("repeat_pulses", 32'(cnt), 32'(exp_rep));
    check_val("key_9", 32'(kb.key), 32'd9);
    #2 reset = 1'b1;
    @(negedge clock);
    check_val("rst_hold_key", 32'(kb.key), 32'd0);
    check_val("rst_hold_held", 32'(kb.key_held), 32'd0);
    check_val("rst_hold_col", 32'(col_out), 32'b1110);
    keys = '0;
    cyc(2);
    #2 reset = 1'b0;
    cyc(20);

    // Randomized presses, bounces and occasional resets
    for (int it = 0; it < 60; it++) begin
      keys = 16'(1) << $urandom_range(0, 15);
      if ($urandom_range(0, 3) == 0) keys = keys | (16'(1) << $urandom_range(0, 15));
      cyc($urandom_range(1, 80));
      keys = '0;
      if ($urandom_range(0, 4) == 0) begin
        ovr_en  = 1'b1;
        ovr_val = 4'($urandom_range(0, 14));
        cyc($urandom_range(1, 14));
        ovr_en  = 1'b0;
      end
      cyc($urandom_range(0, 40));
      if ($urandom_range(0, 9) == 0) pulse_reset($urandom_range(1, 3));
    end
    keys = '0;
    cyc(40);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin : watchdog
    #5000000;
    $display("FAIL watchdog: simulation time limit reached, total=%0d bad=%0d", total, bad);
    $fatal(1);
  end

endmodule
